// File: rtl/imem_loader_pkg.sv
// Shared fetch-side parameters for the instruction-memory loader.
// The checksum helper is shared so both loader and fetch agree on its arithmetic.
package imem_loader_pkg;

  localparam int IMEM_SIZE = 256;

  function automatic logic [31:0] csum_add(input logic [31:0] acc, input logic [31:0] word);
    return acc + word;
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream, memory-write and status bundle of the instruction-memory loader.
interface imem_loader_if;
  logic        start;
  logic [15:0] word_count;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] checksum;

  modport slave (
    input  start, word_count, in_valid, in_data,
    output in_ready, mem_we, mem_addr, mem_wdata, busy, done, err, checksum
  );

  modport master (
    output start, word_count, in_valid, in_data,
    input  in_ready, mem_we, mem_addr, mem_wdata, busy, done, err, checksum
  );
endinterface

// File: rtl/imem_loader_byte_packer.sv
// Big-endian byte packer: holds the first three bytes of a word and presents
// the complete word combinationally while the fourth byte is being accepted.
module byte_packer (
  input  logic        CLK,
  input  logic        RST,
  input  logic        clr,
  input  logic        shift_en,
  input  logic [7:0]  byte_in,
  output logic [31:0] word_next,
  output logic        word_rdy
);

  logic [23:0] hold_r;
  logic [1:0]  cnt_r;

  // Byte shift register and position counter
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      hold_r <= 24'd0;
      cnt_r  <= 2'd0;
    end else if (clr) begin
      hold_r <= 24'd0;
      cnt_r  <= 2'd0;
    end else if (shift_en) begin
      hold_r <= {hold_r[15:0], byte_in};
      cnt_r  <= cnt_r + 2'd1;
    end else begin
      hold_r <= hold_r;
      cnt_r  <= cnt_r;
    end
  end

  assign word_next = {hold_r, byte_in};
  assign word_rdy  = shift_en && (cnt_r == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory loader: packs a byte stream into 32-bit words, writes them
// from address 0 upward, and keeps a running checksum of the words written.
module imem_loader #(
  parameter int IMEM_SIZE = imem_loader_pkg::IMEM_SIZE
) (
  input  logic          CLK,
  input  logic          RST,
  imem_loader_if.slave  bus
);
  import imem_loader_pkg::*;

  localparam int IDX_W = (IMEM_SIZE > 1) ? $clog2(IMEM_SIZE) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state_r, state_nx_s;
  logic [IDX_W-1:0] idx_r, last_idx_r;
  logic             in_ready_r, mem_we_r, busy_r, done_r, err_r;
  logic [31:0]      mem_addr_r, mem_wdata_r, checksum_r;
  logic             accept_s, too_big_s, start_ok_s, csum_clr_s, err_s;
  logic [31:0]      word_next_s;
  logic             word_rdy_s;

  assign accept_s  = bus.in_valid && in_ready_r;
  assign too_big_s = {16'd0, bus.word_count} > 32'(IMEM_SIZE);

  byte_packer u_packer (
    .CLK       (CLK),
    .RST       (RST),
    .clr       (start_ok_s),
    .shift_en  (accept_s),
    .byte_in   (bus.in_data),
    .word_next (word_next_s),
    .word_rdy  (word_rdy_s)
  );

  // Next-state decode and start-request classification
  always_comb begin
    state_nx_s = state_r;
    start_ok_s = 1'b0;
    csum_clr_s = 1'b0;
    err_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.start) begin
          if (too_big_s) begin
            err_s = 1'b1;
          end else if (bus.word_count == 16'd0) begin
            csum_clr_s = 1'b1;
            state_nx_s = DONE;
          end else begin
            csum_clr_s = 1'b1;
            start_ok_s = 1'b1;
            state_nx_s = LOAD;
          end
        end else begin
          state_nx_s = IDLE;
        end
      end
      LOAD:    state_nx_s = word_rdy_s ? WRITE : LOAD;
      WRITE:   state_nx_s = (idx_r == last_idx_r) ? DONE : LOAD;
      DONE:    state_nx_s = IDLE;
      default: state_nx_s = IDLE;
    endcase
  end

  // State, word index and checksum
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_r    <= IDLE;
      idx_r      <= '0;
      last_idx_r <= '0;
      checksum_r <= 32'd0;
    end else begin
      state_r <= state_nx_s;
      if (start_ok_s) begin
        idx_r      <= '0;
        last_idx_r <= IDX_W'(bus.word_count - 16'd1);
      end else if (state_r == WRITE && state_nx_s == LOAD) begin
        idx_r <= idx_r + IDX_W'(1);
      end else begin
        idx_r <= idx_r;
      end
      if (csum_clr_s) begin
        checksum_r <= 32'd0;
      end else if (state_r == WRITE) begin
        checksum_r <= csum_add(checksum_r, mem_wdata_r);
      end else begin
        checksum_r <= checksum_r;
      end
    end
  end

  // Outputs are registered from the next state so they line up with it
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      in_ready_r  <= 1'b0;
      mem_we_r    <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      err_r       <= 1'b0;
      mem_addr_r  <= 32'd0;
      mem_wdata_r <= 32'd0;
    end else begin
      in_ready_r <= (state_nx_s == LOAD);
      mem_we_r   <= (state_nx_s == WRITE);
      busy_r     <= (state_nx_s == LOAD) || (state_nx_s == WRITE);
      done_r     <= (state_nx_s == DONE);
      err_r      <= err_s;
      if (state_nx_s == WRITE) begin
        mem_addr_r  <= {{(30-IDX_W){1'b0}}, idx_r, 2'b00};
        mem_wdata_r <= word_next_s;
      end else begin
        mem_addr_r  <= mem_addr_r;
        mem_wdata_r <= mem_wdata_r;
      end
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.mem_we    = mem_we_r;
  assign bus.mem_addr  = mem_addr_r;
  assign bus.mem_wdata = mem_wdata_r;
  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.err       = err_r;
  assign bus.checksum  = checksum_r;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes are queued by the stimulus
// and matched by a negedge monitor; status pulses are counted alongside.
module tb_imem_loader;

  localparam int SIZE = 256;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  always #5 CLK = ~CLK;

  imem_loader_if bus ();

  imem_loader #(.IMEM_SIZE(SIZE)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  logic [63:0] sb_q[$];
  logic [63:0] exp_w;
  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int cnt_we = 0, cnt_done = 0, cnt_err = 0, cnt_busy = 0;
  int last_we_cyc = 0, last_done_cyc = 0;
  logic [31:0] last_addr = 32'd0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every write and counts status pulses
  always @(negedge CLK) begin
    if (RST) begin
      if (bus.mem_we === 1'b1) begin
        cnt_we++;
        last_addr   = bus.mem_addr;
        last_we_cyc = cyc;
        if (sb_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_write: got addr 0x%08h data 0x%08h expected none", bus.mem_addr, bus.mem_wdata);
        end else begin
          exp_w = sb_q.pop_front();
          check("wr_addr", bus.mem_addr, exp_w[63:32]);
          check("wr_data", bus.mem_wdata, exp_w[31:0]);
        end
      end
      if (bus.done === 1'b1) begin
        cnt_done++;
        last_done_cyc = cyc;
      end
      if (bus.err === 1'b1) cnt_err++;
      if (bus.busy === 1'b1) cnt_busy++;
    end
  end

  task automatic do_start(input logic [15:0] wc);
    @(negedge CLK);
    bus.in_valid   = 1'b0;
    bus.start      = 1'b1;
    bus.word_count = wc;
    @(negedge CLK);
    bus.start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int budget;
    repeat (gap) begin
      @(negedge CLK);
      bus.in_valid = 1'b0;
      bus.in_data  = 8'hEE;
    end
    @(negedge CLK);
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    budget = 0;
    while (bus.in_ready !== 1'b1 && budget < 50) begin
      @(negedge CLK);
      budget++;
    end
    if (budget >= 50) begin
      n_tests++;
      n_fail++;
      $display("FAIL in_ready_timeout: got in_ready 0 expected 1 within 50 cycles");
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    for (int i = 0; i < 4; i++) send_byte(w[31-8*i -: 8], gap);
  endtask

  task automatic wait_done(input int s_done, input string nm);
    int k;
    k = 0;
    @(negedge CLK);
    bus.in_valid = 1'b0;
    while (cnt_done == s_done && k < 2000) begin
      @(posedge CLK);
      k++;
    end
    @(posedge CLK);
    check({nm, "_done_pulses"}, 32'(cnt_done - s_done), 32'd1);
  endtask

  int s_we, s_done, s_err, s_busy;
  logic [31:0] sum, w;

  initial begin
    bus.start = 1'b0; bus.word_count = 16'd0; bus.in_valid = 1'b0; bus.in_data = 8'h00;
    repeat (3) @(negedge CLK);
    check("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
    check("rst_busy",     {31'd0, bus.busy},     32'd0);
    check("rst_mem_addr", bus.mem_addr,          32'd0);
    check("rst_checksum", bus.checksum,          32'd0);
    RST = 1'b1;

    // Two-word load with continuous data
    s_we = cnt_we; s_done = cnt_done;
    sb_q.push_back({32'h0000_0000, 32'h2008_0005});
    sb_q.push_back({32'h0000_0004, 32'h8C11_0004});
    do_start(16'd2);
    send_word(32'h2008_0005, 0);
    send_word(32'h8C11_0004, 0);
    wait_done(s_done, "two_word");
    check("two_word_writes",   32'(cnt_we - s_we), 32'd2);
    check("two_word_checksum", bus.checksum,       32'hAC19_0009);
    check("two_word_done_lat", 32'(last_done_cyc - last_we_cyc), 32'd1);
    check("two_word_busy_end", {31'd0, bus.busy}, 32'd0);

    // One word with in_valid toggling between bytes
    s_we = cnt_we; s_done = cnt_done;
    sb_q.push_back({32'h0000_0000, 32'hDEAD_BEEF});
    do_start(16'd1);
    send_word(32'hDEAD_BEEF, 1);
    wait_done(s_done, "toggle");
    check("toggle_writes",   32'(cnt_we - s_we), 32'd1);
    check("toggle_checksum", bus.checksum,       32'hDEAD_BEEF);

    // Zero-length load
    s_we = cnt_we; s_done = cnt_done;
    do_start(16'd0);
    wait_done(s_done, "zero");
    check("zero_writes",   32'(cnt_we - s_we), 32'd0);
    check("zero_checksum", bus.checksum,       32'd0);

    // Oversized request is rejected
    s_we = cnt_we; s_done = cnt_done; s_err = cnt_err; s_busy = cnt_busy;
    do_start(16'(SIZE + 1));
    repeat (4) @(negedge CLK);
    check("big_err_pulses", 32'(cnt_err - s_err),   32'd1);
    check("big_busy",       32'(cnt_busy - s_busy), 32'd0);
    check("big_writes",     32'(cnt_we - s_we),     32'd0);
    check("big_done",       32'(cnt_done - s_done), 32'd0);

    // Full-depth load
    s_we = cnt_we; s_done = cnt_done;
    sum = 32'd0;
    for (int i = 0; i < SIZE; i++) begin
      w = {i[7:0], ~i[7:0], 8'h5A, i[7:0] ^ 8'hC3};
      sb_q.push_back({32'(i * 4), w});
      sum = sum + w;
    end
    do_start(16'(SIZE));
    for (int i = 0; i < SIZE; i++) send_word({i[7:0], ~i[7:0], 8'h5A, i[7:0] ^ 8'hC3}, 0);
    wait_done(s_done, "full");
    check("full_writes",    32'(cnt_we - s_we), 32'(SIZE));
    check("full_last_addr", last_addr,          32'((SIZE - 1) * 4));
    check("full_checksum",  bus.checksum,       sum);

    // start during LOAD is ignored
    s_we = cnt_we; s_done = cnt_done; s_err = cnt_err;
    sb_q.push_back({32'h0000_0000, 32'h1122_3344});
    do_start(16'd1);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    do_start(16'd3);
    send_byte(8'h33, 0);
    send_byte(8'h44, 0);
    wait_done(s_done, "ignore");
    check("ignore_err",    32'(cnt_err - s_err), 32'd0);
    check("ignore_writes", 32'(cnt_we - s_we),   32'd1);
    check("ignore_sb",     32'(sb_q.size()),     32'd0);

    // Asynchronous reset mid-word
    sb_q.push_back({32'h0000_0000, 32'hCAFE_F00D});
    do_start(16'd2);
    send_word(32'hCAFE_F00D, 0);
    send_byte(8'h01, 0);
    send_byte(8'h02, 0);
    @(negedge CLK);
    bus.in_valid = 1'b0;
    #2 RST = 1'b0;
    #1;
    check("arst_in_ready",  {31'd0, bus.in_ready}, 32'd0);
    check("arst_mem_we",    {31'd0, bus.mem_we},   32'd0);
    check("arst_mem_addr",  bus.mem_addr,          32'd0);
    check("arst_mem_wdata", bus.mem_wdata,         32'd0);
    check("arst_busy",      {31'd0, bus.busy},     32'd0);
    check("arst_done",      {31'd0, bus.done},     32'd0);
    check("arst_err",       {31'd0, bus.err},      32'd0);
    check("arst_checksum",  bus.checksum,          32'd0);
    check("arst_sb",        32'(sb_q.size()),      32'd0);
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    s_we = cnt_we; s_done = cnt_done;
    sb_q.push_back({32'h0000_0000, 32'h0BAD_C0DE});
    do_start(16'd1);
    send_word(32'h0BAD_C0DE, 0);
    wait_done(s_done, "post_rst");
    check("post_rst_writes",   32'(cnt_we - s_we), 32'd1);
    check("post_rst_addr",     last_addr,          32'd0);
    check("post_rst_checksum", bus.checksum,       32'h0BAD_C0DE);
    check("final_sb_empty",    32'(sb_q.size()),   32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
